axi4_mem_model: RTL and testbench
=================================

# axi4_mem_model

Behavioural AXI4 slave memory for the simulation harness, attached directly downstream of one `mem_N` channel of FPGATop in the emulation top. It stands in for host DRAM whenever a testbench runs without the DPI memory driver. The block accepts one read burst and one write burst at a time. Reads and writes proceed independently. Storage is an internal byte-writable word array.

## Interface
Parameters:
- `ADDR_BITS`, 32: AXI address width.
- `DATA_BITS`, 64: data width; power of two, at least 8.
- `ID_BITS`, 4: AXI ID width.
- `DEPTH_WORDS`, 4096: number of storage words; power of two.
- `READ_LATENCY`, 4: number of extra wait cycles before the first R beat; used only under `AXI4_MEM_MODEL_LATENCY_EN`.

Ports:
- `clock`, in, 1: the single clock.
- `reset_n`, in, 1: asynchronous active-low reset.
- `mem_ar_valid`, in, 1; `mem_ar_ready`, out, 1; `mem_ar_bits_addr`/`_id`/`_size`/`_len`, in, ADDR_BITS/ID_BITS/3/8: read address channel.
- `mem_aw_valid`, in, 1; `mem_aw_ready`, out, 1; `mem_aw_bits_addr`/`_id`/`_size`/`_len`, in, ADDR_BITS/ID_BITS/3/8: write address channel.
- `mem_w_valid`, in, 1; `mem_w_ready`, out, 1; `mem_w_bits_data`/`_strb`/`_last`, in, DATA_BITS/DATA_BITS/8/1: write data channel.
- `mem_r_valid`, out, 1; `mem_r_ready`, in, 1; `mem_r_bits_data`/`_id`/`_resp`/`_last`, out, DATA_BITS/ID_BITS/2/1: read data channel.
- `mem_b_valid`, out, 1; `mem_b_ready`, in, 1; `mem_b_bits_id`/`_resp`, out, ID_BITS/2: write response channel.

## Operation
- Only INCR bursts are supported.
- Beat address advances by `1 << size`. Requests must satisfy size ≤ log2(DATA_BITS/8).
- Word index is `addr[log2(DEPTH_WORDS)+log2(DATA_BITS/8)-1 : log2(DATA_BITS/8)]`. Higher address bits are ignored, so accesses alias modulo the array size.
- Read FSM states:
  - `R_IDLE`: `ar_ready`=1. An AR handshake latches addr, id, size, len and moves to `R_WAIT` (latency build) or `R_BURST`.
  - `R_WAIT`: counts down `READ_LATENCY`, then moves to `R_BURST`.
  - `R_BURST`: `r_valid`=1 and `r_resp`=OKAY.
    - `r_last`=1 on beat len+1.
    - An R handshake advances the beat.
    - The handshake on the last beat returns to `R_IDLE`.
- Write FSM states:
  - `W_IDLE`: `aw_ready`=1. An AW handshake moves to `W_DATA`.
  - `W_DATA`: `w_ready`=1. Each W handshake writes the bytes whose `strb` bit is set; `strb`=0 bytes keep their old value.
  - The burst ends on beat count len+1, independent of `w_last`. The block then moves to `W_RESP`.
  - `W_RESP`: `b_valid`=1 and `b_id` = the latched AW id.
  - `b_resp`=SLVERR (2'b10) if any beat's `w_last` disagreed with its position in the burst; otherwise OKAY.
  - A B handshake returns to `W_IDLE`.
- A read and a write hitting the same word in the same cycle: R returns the old data (read-before-write).
- Assertion of `reset_n` mid-burst abandons the burst and returns both FSMs to IDLE.
- Memory contents survive reset and are not initialised by reset.

## Timing
- Reset values of outputs: every `valid`/`ready` is 0 while `reset_n`=0. Data, id, resp and last outputs are 0.
- First cycle after deassertion: `ar_ready`=1 and `aw_ready`=1.
- Read: an AR handshake in cycle T makes `ar_ready`=0 from T+1. The first R beat is valid at T+1, or at T+1+READ_LATENCY with latency enabled. After that, one beat is issued per cycle while `r_ready` is high.
- While `r_valid`=1 and `r_ready`=0, every R output holds stable.
- `ar_ready` returns to 1 in the cycle after the last-beat handshake. Maximum read throughput is (len+1) beats per len+2 cycles.
- Write: an AW handshake in T gives `w_ready`=1 from T+1. The final W handshake in cycle U gives `w_ready`=0 and `b_valid`=1 at U+1. A B handshake in V gives `aw_ready`=1 at V+1.
- W beats presented before the AW handshake are not accepted.

## Configuration
- `AXI4_MEM_MODEL_LATENCY_EN`:
  - Defined: `R_WAIT` and its counter exist, adding READ_LATENCY wait cycles before the first R beat.
  - Undefined: `R_WAIT` is absent and the first beat appears at T+1.

## Structure
- Package `axi4_mem_model_pkg` holds:
  - response constants `RESP_OKAY`=2'b00 and `RESP_SLVERR`=2'b10;
  - read/write FSM state enums;
  - a function computing the next burst address.
- One sub-module, `axi4_mem_model_ram`: DEPTH_WORDS×DATA_BITS storage with a byte-enable write port and an asynchronous read port. It provides the read-before-write ordering.

## Test plan
- Read after write: write len=3 to 0x100 with data 0x11..0x44 and full strb, then read len=3 from 0x100. Expect b_resp=0, the same four words back, and r_last only on the 4th beat.
- Partial strobe: write 0xFFFF_FFFF_FFFF_FFFF to 0x0, then write 0x0 to 0x0 with strb=0x0F. Read at 0x0 returns 0xFFFF_FFFF_0000_0000.
- Backpressure: during a len=7 read, hold r_ready=0 for 5 cycles at beat 3. R outputs stay stable, and all 8 beats arrive in order with no loss.
- w_last mismatch: len=3 burst with w_last on beat 2. Four beats are still accepted, then b_resp=2'b10.
- Reset mid-burst: drop reset_n during beat 2 of a len=7 read. All valids go to 0, then ar_ready=1 and aw_ready=1 after release. A new read returns the old memory contents.
- Latency (LATENCY_EN, READ_LATENCY=4): AR handshake at T gives first r_valid at T+5.

Source files
------------

// File: rtl/axi4_mem_model_pkg.sv
// Shared types and helpers for the behavioural AXI4 slave memory.
// R_WAIT exists only when AXI4_MEM_MODEL_LATENCY_EN is defined.
package axi4_mem_model_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Widest address the burst helper handles; callers cast to their width.
    localparam int AXI_ADDR_MAX = 64;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_BURST = 2'd1
`ifdef AXI4_MEM_MODEL_LATENCY_EN
        , R_WAIT = 2'd2
`endif
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // INCR burst: each beat advances by the transfer size in bytes.
    function automatic logic [AXI_ADDR_MAX-1:0] next_burst_addr(
        input logic [AXI_ADDR_MAX-1:0] addr,
        input logic [2:0]              size
    );
        return addr + (AXI_ADDR_MAX'(1) << size);
    endfunction

endpackage

// File: rtl/axi4_mem_model_ram.sv
// Byte-writable word storage: synchronous byte-enable write, asynchronous read.
// A read of the word being written in the same cycle sees the old contents,
// since the write only lands at the clock edge. Contents are never reset.
module axi4_mem_model_ram #(
    parameter int DEPTH_WORDS = 4096,
    parameter int DATA_BITS   = 64,
    localparam int IDX_BITS   = $clog2(DEPTH_WORDS),
    localparam int NBYTES     = DATA_BITS / 8
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [IDX_BITS-1:0]  i_waddr,
    input  logic [DATA_BITS-1:0] i_wdata,
    input  logic [NBYTES-1:0]    i_wstrb,
    input  logic [IDX_BITS-1:0]  i_raddr,
    output logic [DATA_BITS-1:0] o_rdata
);

    logic [DATA_BITS-1:0] r_mem [DEPTH_WORDS];

    // Byte-lane write: lanes with a clear strobe keep their old value
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < NBYTES; b++) begin
            if (i_we && i_wstrb[b]) begin
                r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axi4_mem_model.sv
// Behavioural AXI4 slave memory: one read burst and one write burst in flight,
// independent read/write FSMs, INCR bursts only, addresses alias modulo size.
// Define AXI4_MEM_MODEL_LATENCY_EN to insert READ_LATENCY wait cycles before
// the first R beat of every burst.
module axi4_mem_model
    import axi4_mem_model_pkg::*;
#(
    parameter int ADDR_BITS    = 32,
    parameter int DATA_BITS    = 64,
    parameter int ID_BITS      = 4,
    parameter int DEPTH_WORDS  = 4096,
    parameter int READ_LATENCY = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   mem_ar_valid,
    output logic                   mem_ar_ready,
    input  logic [ADDR_BITS-1:0]   mem_ar_bits_addr,
    input  logic [ID_BITS-1:0]     mem_ar_bits_id,
    input  logic [2:0]             mem_ar_bits_size,
    input  logic [7:0]             mem_ar_bits_len,
    input  logic                   mem_aw_valid,
    output logic                   mem_aw_ready,
    input  logic [ADDR_BITS-1:0]   mem_aw_bits_addr,
    input  logic [ID_BITS-1:0]     mem_aw_bits_id,
    input  logic [2:0]             mem_aw_bits_size,
    input  logic [7:0]             mem_aw_bits_len,
    input  logic                   mem_w_valid,
    output logic                   mem_w_ready,
    input  logic [DATA_BITS-1:0]   mem_w_bits_data,
    input  logic [DATA_BITS/8-1:0] mem_w_bits_strb,
    input  logic                   mem_w_bits_last,
    output logic                   mem_r_valid,
    input  logic                   mem_r_ready,
    output logic [DATA_BITS-1:0]   mem_r_bits_data,
    output logic [ID_BITS-1:0]     mem_r_bits_id,
    output logic [1:0]             mem_r_bits_resp,
    output logic                   mem_r_bits_last,
    output logic                   mem_b_valid,
    input  logic                   mem_b_ready,
    output logic [ID_BITS-1:0]     mem_b_bits_id,
    output logic [1:0]             mem_b_bits_resp
);

    localparam int BYTE_BITS = $clog2(DATA_BITS / 8);
    localparam int IDX_BITS  = $clog2(DEPTH_WORDS);

    // ---------------- read side ----------------
    rd_state_t             r_rd_state, w_rd_next;
    logic [ADDR_BITS-1:0]  r_raddr;
    logic [ID_BITS-1:0]    r_rid;
    logic [2:0]            r_rsize;
    logic [7:0]            r_rlen;
    logic [7:0]            r_rbeat;
    logic                  w_ar_hs, w_r_hs, w_r_last_beat;
    logic [ADDR_BITS-1:0]  w_raddr_next;
    logic [DATA_BITS-1:0]  w_ram_rdata;
`ifdef AXI4_MEM_MODEL_LATENCY_EN
    logic [15:0]           r_lat_cnt;
`endif

    assign w_ar_hs       = mem_ar_valid & mem_ar_ready;
    assign w_r_hs        = mem_r_valid & mem_r_ready;
    assign w_r_last_beat = (r_rbeat == r_rlen);
    assign w_raddr_next  = ADDR_BITS'(next_burst_addr(AXI_ADDR_MAX'(r_raddr), r_rsize));

    // Read FSM state register; reset abandons any burst in progress
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_rd_state <= R_IDLE;
        else          r_rd_state <= w_rd_next;
    end

    // Read FSM next-state logic
    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            R_IDLE: begin
                if (w_ar_hs) begin
`ifdef AXI4_MEM_MODEL_LATENCY_EN
                    w_rd_next = (READ_LATENCY == 0) ? R_BURST : R_WAIT;
`else
                    w_rd_next = R_BURST;
`endif
                end
            end
`ifdef AXI4_MEM_MODEL_LATENCY_EN
            R_WAIT: begin
                if (r_lat_cnt == 16'd0) w_rd_next = R_BURST;
            end
`endif
            R_BURST: begin
                if (w_r_hs && w_r_last_beat) w_rd_next = R_IDLE;
            end
            default: w_rd_next = R_IDLE;
        endcase
    end

    // Read FSM outputs; payload is forced to zero whenever no beat is offered.
    // ar_ready is qualified with reset_n so it reads 0 throughout reset.
    always_comb begin
        mem_ar_ready    = reset_n && (r_rd_state == R_IDLE);
        mem_r_valid     = (r_rd_state == R_BURST);
        mem_r_bits_data = '0;
        mem_r_bits_id   = '0;
        mem_r_bits_resp = RESP_OKAY;
        mem_r_bits_last = 1'b0;
        if (r_rd_state == R_BURST) begin
            mem_r_bits_data = w_ram_rdata;
            mem_r_bits_id   = r_rid;
            mem_r_bits_last = w_r_last_beat;
        end
    end

    // Read burst bookkeeping: latch AR fields, advance address per R handshake
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_raddr <= '0;
            r_rid   <= '0;
            r_rsize <= '0;
            r_rlen  <= '0;
            r_rbeat <= '0;
        end else if (w_ar_hs) begin
            r_raddr <= mem_ar_bits_addr;
            r_rid   <= mem_ar_bits_id;
            r_rsize <= mem_ar_bits_size;
            r_rlen  <= mem_ar_bits_len;
            r_rbeat <= '0;
        end else if (w_r_hs) begin
            r_raddr <= w_raddr_next;
            r_rbeat <= r_rbeat + 8'd1;
        end
    end

`ifdef AXI4_MEM_MODEL_LATENCY_EN
    // Wait counter: loaded on AR so R_WAIT lasts exactly READ_LATENCY cycles
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                                        r_lat_cnt <= '0;
        else if (w_ar_hs)                                    r_lat_cnt <= 16'(READ_LATENCY - 1);
        else if (r_rd_state == R_WAIT && r_lat_cnt != 16'd0) r_lat_cnt <= r_lat_cnt - 16'd1;
    end
`endif

    // ---------------- write side ----------------
    wr_state_t             r_wr_state, w_wr_next;
    logic [ADDR_BITS-1:0]  r_waddr;
    logic [ID_BITS-1:0]    r_wid;
    logic [2:0]            r_wsize;
    logic [7:0]            r_wlen;
    logic [7:0]            r_wbeat;
    logic                  r_werr;
    logic                  w_aw_hs, w_w_hs, w_w_last_beat, w_last_bad;
    logic [ADDR_BITS-1:0]  w_waddr_next;

    assign w_aw_hs       = mem_aw_valid & mem_aw_ready;
    assign w_w_hs        = mem_w_valid & mem_w_ready;
    assign w_w_last_beat = (r_wbeat == r_wlen);
    // Burst length comes from AWLEN; w_last is only checked, never obeyed
    assign w_last_bad    = (mem_w_bits_last != w_w_last_beat);
    assign w_waddr_next  = ADDR_BITS'(next_burst_addr(AXI_ADDR_MAX'(r_waddr), r_wsize));

    // Write FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_wr_state <= W_IDLE;
        else          r_wr_state <= w_wr_next;
    end

    // Write FSM next-state logic
    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if (w_aw_hs) w_wr_next = W_DATA;
            W_DATA:  if (w_w_hs && w_w_last_beat) w_wr_next = W_RESP;
            W_RESP:  if (mem_b_valid && mem_b_ready) w_wr_next = W_IDLE;
            default: w_wr_next = W_IDLE;
        endcase
    end

    // Write FSM outputs
    always_comb begin
        mem_aw_ready    = reset_n && (r_wr_state == W_IDLE);
        mem_w_ready     = (r_wr_state == W_DATA);
        mem_b_valid     = (r_wr_state == W_RESP);
        mem_b_bits_id   = '0;
        mem_b_bits_resp = RESP_OKAY;
        if (r_wr_state == W_RESP) begin
            mem_b_bits_id   = r_wid;
            mem_b_bits_resp = r_werr ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Write burst bookkeeping: latch AW fields, track beats and w_last errors
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_waddr <= '0;
            r_wid   <= '0;
            r_wsize <= '0;
            r_wlen  <= '0;
            r_wbeat <= '0;
            r_werr  <= 1'b0;
        end else if (w_aw_hs) begin
            r_waddr <= mem_aw_bits_addr;
            r_wid   <= mem_aw_bits_id;
            r_wsize <= mem_aw_bits_size;
            r_wlen  <= mem_aw_bits_len;
            r_wbeat <= '0;
            r_werr  <= 1'b0;
        end else if (w_w_hs) begin
            r_waddr <= w_waddr_next;
            r_wbeat <= r_wbeat + 8'd1;
            r_werr  <= r_werr | w_last_bad;
        end
    end

    axi4_mem_model_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_BITS   (DATA_BITS)
    ) u_ram (
        .i_clk   (clock),
        .i_we    (w_w_hs),
        .i_waddr (r_waddr[IDX_BITS+BYTE_BITS-1:BYTE_BITS]),
        .i_wdata (mem_w_bits_data),
        .i_wstrb (mem_w_bits_strb),
        .i_raddr (r_raddr[IDX_BITS+BYTE_BITS-1:BYTE_BITS]),
        .o_rdata (w_ram_rdata)
    );

endmodule

// File: tb/tb_axi4_mem_model.sv
// Directed bench for axi4_mem_model with a read-data scoreboard and a
// byte-level reference memory. Honours AXI4_MEM_MODEL_LATENCY_EN.
module tb_axi4_mem_model;

    localparam int READ_LATENCY = 4;
`ifdef AXI4_MEM_MODEL_LATENCY_EN
    localparam int EXP_LAT = READ_LATENCY;
`else
    localparam int EXP_LAT = 0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        mem_ar_valid, mem_ar_ready;
    logic [31:0] mem_ar_bits_addr;
    logic [3:0]  mem_ar_bits_id;
    logic [2:0]  mem_ar_bits_size;
    logic [7:0]  mem_ar_bits_len;
    logic        mem_aw_valid, mem_aw_ready;
    logic [31:0] mem_aw_bits_addr;
    logic [3:0]  mem_aw_bits_id;
    logic [2:0]  mem_aw_bits_size;
    logic [7:0]  mem_aw_bits_len;
    logic        mem_w_valid, mem_w_ready;
    logic [63:0] mem_w_bits_data;
    logic [7:0]  mem_w_bits_strb;
    logic        mem_w_bits_last;
    logic        mem_r_valid, mem_r_ready;
    logic [63:0] mem_r_bits_data;
    logic [3:0]  mem_r_bits_id;
    logic [1:0]  mem_r_bits_resp;
    logic        mem_r_bits_last;
    logic        mem_b_valid, mem_b_ready;
    logic [3:0]  mem_b_bits_id;
    logic [1:0]  mem_b_bits_resp;

    int checks   = 0;
    int failures = 0;

    logic [63:0] model [int];
    logic [63:0] exp_q [$];
    logic [63:0] wbuf [16];
    logic [7:0]  sbuf [16];
    logic [63:0] last_rdata;

    axi4_mem_model #(
        .ADDR_BITS(32), .DATA_BITS(64), .ID_BITS(4),
        .DEPTH_WORDS(4096), .READ_LATENCY(READ_LATENCY)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready),
        .mem_ar_bits_addr(mem_ar_bits_addr), .mem_ar_bits_id(mem_ar_bits_id),
        .mem_ar_bits_size(mem_ar_bits_size), .mem_ar_bits_len(mem_ar_bits_len),
        .mem_aw_valid(mem_aw_valid), .mem_aw_ready(mem_aw_ready),
        .mem_aw_bits_addr(mem_aw_bits_addr), .mem_aw_bits_id(mem_aw_bits_id),
        .mem_aw_bits_size(mem_aw_bits_size), .mem_aw_bits_len(mem_aw_bits_len),
        .mem_w_valid(mem_w_valid), .mem_w_ready(mem_w_ready),
        .mem_w_bits_data(mem_w_bits_data), .mem_w_bits_strb(mem_w_bits_strb),
        .mem_w_bits_last(mem_w_bits_last),
        .mem_r_valid(mem_r_valid), .mem_r_ready(mem_r_ready),
        .mem_r_bits_data(mem_r_bits_data), .mem_r_bits_id(mem_r_bits_id),
        .mem_r_bits_resp(mem_r_bits_resp), .mem_r_bits_last(mem_r_bits_last),
        .mem_b_valid(mem_b_valid), .mem_b_ready(mem_b_ready),
        .mem_b_bits_id(mem_b_bits_id), .mem_b_bits_resp(mem_b_bits_resp)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic int widx(input logic [31:0] addr);
        return int'((addr >> 3) & 32'h0000_0FFF);
    endfunction

    function automatic void mwrite(input logic [31:0] addr, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] w;
        w = model.exists(widx(addr)) ? model[widx(addr)] : 64'h0;
        for (int b = 0; b < 8; b++)
            if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
        model[widx(addr)] = w;
    endfunction

    // Write burst of len+1 beats from wbuf/sbuf; w_last asserted on beat last_pos
    task automatic wr_burst(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                            input int last_pos, input logic [1:0] exp_resp);
        int n;
        mem_aw_valid = 1'b1; mem_aw_bits_addr = addr; mem_aw_bits_id = id;
        mem_aw_bits_size = 3'd3; mem_aw_bits_len = len;
        n = 0;
        while (!mem_aw_ready && n < 50) begin step(); n++; end
        chk("aw_ready", 64'(mem_aw_ready), 64'd1);
        step();
        mem_aw_valid = 1'b0;
        chk("aw_ready_drop", 64'(mem_aw_ready), 64'd0);
        chk("w_ready_rise", 64'(mem_w_ready), 64'd1);
        for (int i = 0; i <= int'(len); i++) begin
            mem_w_valid = 1'b1; mem_w_bits_data = wbuf[i]; mem_w_bits_strb = sbuf[i];
            mem_w_bits_last = (i == last_pos);
            n = 0;
            while (!mem_w_ready && n < 50) begin step(); n++; end
            chk("w_beat_accept", 64'(mem_w_ready), 64'd1);
            mwrite(addr + 32'(i * 8), wbuf[i], sbuf[i]);
            step();
        end
        mem_w_valid = 1'b0; mem_w_bits_last = 1'b0;
        chk("b_valid", 64'(mem_b_valid), 64'd1);
        chk("w_ready_end", 64'(mem_w_ready), 64'd0);
        chk("b_resp", 64'(mem_b_bits_resp), 64'(exp_resp));
        chk("b_id", 64'(mem_b_bits_id), 64'(id));
        mem_b_ready = 1'b1;
        step();
        mem_b_ready = 1'b0;
        chk("aw_ready_ret", 64'(mem_aw_ready), 64'd1);
    endtask

    // Read burst with scoreboard; optional stall at a beat, optional reset at a beat
    task automatic rd_burst(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                            input int stall_beat, input int stall_cyc, input int abort_at);
        int n;
        logic [63:0] snap_d, e;
        logic        snap_l;
        for (int i = 0; i <= int'(len); i++)
            exp_q.push_back(model[widx(addr + 32'(i * 8))]);
        mem_r_ready = 1'b0;
        mem_ar_valid = 1'b1; mem_ar_bits_addr = addr; mem_ar_bits_id = id;
        mem_ar_bits_size = 3'd3; mem_ar_bits_len = len;
        n = 0;
        while (!mem_ar_ready && n < 50) begin step(); n++; end
        chk("ar_ready", 64'(mem_ar_ready), 64'd1);
        step();
        mem_ar_valid = 1'b0;
        chk("ar_ready_drop", 64'(mem_ar_ready), 64'd0);
        n = 0;
        while (!mem_r_valid && n < 100) begin step(); n++; end
        chk("r_first_latency", 64'(n), 64'(EXP_LAT));
        for (int i = 0; i <= int'(len); i++) begin
            if (i == abort_at) begin
                mem_r_ready = 1'b0;
                reset_n = 1'b0;
                #1;
                chk("rst_r_valid", 64'(mem_r_valid), 64'd0);
                chk("rst_ar_ready", 64'(mem_ar_ready), 64'd0);
                chk("rst_aw_ready", 64'(mem_aw_ready), 64'd0);
                chk("rst_r_data", mem_r_bits_data, 64'd0);
                step();
                reset_n = 1'b1;
                #1;
                chk("rel_ar_ready", 64'(mem_ar_ready), 64'd1);
                chk("rel_aw_ready", 64'(mem_aw_ready), 64'd1);
                chk("rel_r_valid", 64'(mem_r_valid), 64'd0);
                exp_q.delete();
                return;
            end
            if (i == stall_beat) begin
                mem_r_ready = 1'b0;
                snap_d = mem_r_bits_data; snap_l = mem_r_bits_last;
                repeat (stall_cyc) begin
                    step();
                    chk("stall_valid", 64'(mem_r_valid), 64'd1);
                    chk("stall_data", mem_r_bits_data, snap_d);
                    chk("stall_last", 64'(mem_r_bits_last), 64'(snap_l));
                end
            end
            mem_r_ready = 1'b1;
            n = 0;
            while (!mem_r_valid && n < 50) begin step(); n++; end
            chk("r_valid", 64'(mem_r_valid), 64'd1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
            chk("r_data", mem_r_bits_data, e);
            chk("r_last", 64'(mem_r_bits_last), 64'(i == int'(len)));
            chk("r_id", 64'(mem_r_bits_id), 64'(id));
            chk("r_resp", 64'(mem_r_bits_resp), 64'd0);
            last_rdata = mem_r_bits_data;
            step();
        end
        mem_r_ready = 1'b0;
        chk("ar_ready_ret", 64'(mem_ar_ready), 64'd1);
        chk("r_valid_end", 64'(mem_r_valid), 64'd0);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        mem_ar_valid = 0; mem_ar_bits_addr = 0; mem_ar_bits_id = 0; mem_ar_bits_size = 0; mem_ar_bits_len = 0;
        mem_aw_valid = 0; mem_aw_bits_addr = 0; mem_aw_bits_id = 0; mem_aw_bits_size = 0; mem_aw_bits_len = 0;
        mem_w_valid = 0; mem_w_bits_data = 0; mem_w_bits_strb = 0; mem_w_bits_last = 0;
        mem_r_ready = 0; mem_b_ready = 0;
        repeat (3) @(negedge clock);
        // Outputs while held in reset
        chk("reset_ar_ready", 64'(mem_ar_ready), 64'd0);
        chk("reset_aw_ready", 64'(mem_aw_ready), 64'd0);
        chk("reset_w_ready", 64'(mem_w_ready), 64'd0);
        chk("reset_r_valid", 64'(mem_r_valid), 64'd0);
        chk("reset_b_valid", 64'(mem_b_valid), 64'd0);
        chk("reset_r_data", mem_r_bits_data, 64'd0);
        chk("reset_b_resp", 64'(mem_b_bits_resp), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("post_reset_ar_ready", 64'(mem_ar_ready), 64'd1);
        chk("post_reset_aw_ready", 64'(mem_aw_ready), 64'd1);

        // W data before any AW is not accepted
        mem_w_valid = 1'b1; mem_w_bits_data = 64'hABCD; mem_w_bits_strb = 8'hFF;
        step();
        chk("w_before_aw", 64'(mem_w_ready), 64'd0);
        step();
        chk("w_before_aw2", 64'(mem_w_ready), 64'd0);
        mem_w_valid = 1'b0;

        // Read after write, len=3 at 0x100
        wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
        for (int i = 0; i < 4; i++) sbuf[i] = 8'hFF;
        wr_burst(32'h100, 8'd3, 4'd1, 3, 2'b00);
        rd_burst(32'h100, 8'd3, 4'd2, -1, 0, -1);
        chk("raw_last_word", last_rdata, 64'h44);

        // Partial strobe at 0x0
        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF; sbuf[0] = 8'hFF;
        wr_burst(32'h0, 8'd0, 4'd3, 0, 2'b00);
        wbuf[0] = 64'h0; sbuf[0] = 8'h0F;
        wr_burst(32'h0, 8'd0, 4'd3, 0, 2'b00);
        rd_burst(32'h0, 8'd0, 4'd4, -1, 0, -1);
        chk("partial_strb", last_rdata, 64'hFFFF_FFFF_0000_0000);

        // Aliasing: address one array-size above 0x100 hits the same word
        rd_burst(32'h100 + 32'h8000, 8'd0, 4'd5, -1, 0, -1);
        chk("alias_word", last_rdata, 64'h11);

        // Backpressure: len=7 read, r_ready low 5 cycles at beat 3
        for (int i = 0; i < 8; i++) begin
            wbuf[i] = {32'hC0DE_0000 | 32'(i), $urandom}; sbuf[i] = 8'hFF;
        end
        wr_burst(32'h200, 8'd7, 4'd6, 7, 2'b00);
        rd_burst(32'h200, 8'd7, 4'd7, 3, 5, -1);

        // w_last on beat 2 of a 4-beat burst: all beats taken, SLVERR
        for (int i = 0; i < 4; i++) begin wbuf[i] = 64'h5000 + 64'(i); sbuf[i] = 8'hFF; end
        wr_burst(32'h400, 8'd3, 4'd9, 1, 2'b10);
        rd_burst(32'h400, 8'd3, 4'd10, -1, 0, -1);
        chk("wlast_err_data", last_rdata, 64'h5003);

        // Same-word read and write in one cycle: read sees old contents
        mem_ar_valid = 1'b1; mem_ar_bits_addr = 32'h100; mem_ar_bits_id = 4'd11;
        mem_ar_bits_size = 3'd3; mem_ar_bits_len = 8'd0;
        mem_aw_valid = 1'b1; mem_aw_bits_addr = 32'h100; mem_aw_bits_id = 4'd12;
        mem_aw_bits_size = 3'd3; mem_aw_bits_len = 8'd0;
        step();
        mem_ar_valid = 1'b0; mem_aw_valid = 1'b0;
        n = 0;
        while (!mem_r_valid && n < 100) begin step(); n++; end
        mem_w_valid = 1'b1; mem_w_bits_data = 64'hDEAD_BEEF_0BAD_F00D;
        mem_w_bits_strb = 8'hFF; mem_w_bits_last = 1'b1; mem_r_ready = 1'b1;
        chk("rbw_w_ready", 64'(mem_w_ready), 64'd1);
        chk("rbw_r_valid", 64'(mem_r_valid), 64'd1);
        chk("rbw_old_data", mem_r_bits_data, 64'h11);
        step();
        mwrite(32'h100, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
        mem_w_valid = 1'b0; mem_w_bits_last = 1'b0; mem_r_ready = 1'b0;
        chk("rbw_b_valid", 64'(mem_b_valid), 64'd1);
        chk("rbw_b_id", 64'(mem_b_bits_id), 64'd12);
        mem_b_ready = 1'b1;
        step();
        mem_b_ready = 1'b0;
        rd_burst(32'h100, 8'd0, 4'd13, -1, 0, -1);
        chk("rbw_new_data", last_rdata, 64'hDEAD_BEEF_0BAD_F00D);

        // Reset during beat 2 of a len=7 read, then memory survives
        rd_burst(32'h200, 8'd7, 4'd14, -1, 0, 1);
        rd_burst(32'h100, 8'd3, 4'd15, -1, 0, -1);
        rd_burst(32'h200, 8'd7, 4'd1, -1, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
